// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the CNN window multiply-accumulate datapath.
//
// Contents:
//   DEF_DATA_WIDTH / DEF_BLOCK_SIZE / DEF_FRAC_BITS : default Q8.8, 5x5 window
//   DEF_SAT_MAX / DEF_SAT_MIN                       : signed clamp limits at the
//                                                     default data width
//   conv_state_t                                    : MAC engine FSM states
// -----------------------------------------------------------------------------
package cnn_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_BLOCK_SIZE = 25;
   localparam int DEF_FRAC_BITS  = 8;

   localparam logic signed [DEF_DATA_WIDTH-1:0] DEF_SAT_MAX = 16'sh7FFF;
   localparam logic signed [DEF_DATA_WIDTH-1:0] DEF_SAT_MIN = 16'sh8000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      SAT  = 2'd2,
      HOLD = 2'd3
   } conv_state_t;

endpackage

// File: rtl/fx_shift_sat.sv
// -----------------------------------------------------------------------------
// fx_shift_sat
// Combinational fixed-point rescale: arithmetic right shift of the wide
// accumulator by FRAC_BITS (truncation toward -inf), then clamp to the signed
// DATA_WIDTH range.
//
// Configuration macro: CONV_RELU_EN -- when defined, negative clamped values
// are forced to zero.
//
// Ports:
//   acc_i : ACC_WIDTH signed accumulator
//   sat_o : DATA_WIDTH signed rescaled, saturated value
// -----------------------------------------------------------------------------
module fx_shift_sat #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+5
) (
   input  logic signed [ACC_WIDTH-1:0]  acc_i,
   output logic signed [DATA_WIDTH-1:0] sat_o
);

   localparam logic signed [DATA_WIDTH-1:0] SatMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] SatMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [ACC_WIDTH-1:0]  MaxExt = ACC_WIDTH'(SatMax);
   localparam logic signed [ACC_WIDTH-1:0]  MinExt = ACC_WIDTH'(SatMin);

   logic signed [ACC_WIDTH-1:0]  shifted;
   logic signed [DATA_WIDTH-1:0] clamped;

   // Drop the fractional bits of the product sum. The shift is arithmetic, so
   // negative sums round toward minus infinity rather than toward zero.
   always_comb begin
      shifted = acc_i >>> FRAC_BITS;
   end

   // Clamp into the representable output range; the low bits are only taken
   // once the value is known to fit.
   always_comb begin
      clamped = shifted[DATA_WIDTH-1:0];
      if (shifted > MaxExt) begin
         clamped = SatMax;
      end else if (shifted < MinExt) begin
         clamped = SatMin;
      end
   end

`ifdef CONV_RELU_EN
   // Rectify: anything negative after saturation becomes zero.
   always_comb begin
      sat_o = clamped;
      if (clamped[DATA_WIDTH-1]) begin
         sat_o = '0;
      end
   end
`else
   // Signed saturated value passes straight through.
   always_comb begin
      sat_o = clamped;
   end
`endif

endmodule

// File: rtl/conv_window_mac.sv
// -----------------------------------------------------------------------------
// conv_window_mac
// Signed fixed-point dot product of one flattened activation window with a
// matching weight block, using one shared multiplier over BLOCK_SIZE cycles,
// followed by rescale/saturation and a valid/ready result handshake.
//
// Configuration macro: CONV_RELU_EN (handled inside fx_shift_sat) -- clamps
// negative results to zero; latency unchanged.
//
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-high reset, aborts any operation
//   start      : operation request, only looked at while idle
//   window_in  : activation block, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   weight_in  : weight block, same packing
//   busy       : high whenever the engine is not idle
//   out_valid  : result is available
//   out_ready  : consumer takes the result
//   result     : signed saturated dot product
// -----------------------------------------------------------------------------
module conv_window_mac
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
   parameter int FRAC_BITS  = DEF_FRAC_BITS,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+5
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] window_in,
   input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] weight_in,
   output logic                             busy,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH-1:0]            result
);

   localparam int IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE-1);

   conv_state_t state_q, state_d;

   logic signed [DATA_WIDTH-1:0]   win_q [BLOCK_SIZE];
   logic signed [DATA_WIDTH-1:0]   wgt_q [BLOCK_SIZE];
   logic [IDX_W-1:0]               idx_q;
   logic signed [ACC_WIDTH-1:0]    acc_q;
   logic signed [DATA_WIDTH-1:0]   result_q;
   logic                           out_valid_q;

   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [DATA_WIDTH-1:0]   sat_val;

   // State register; reset always lands in IDLE so an abort leaves nothing
   // pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. start is only honoured in IDLE and out_ready only in
   // HOLD, so returning to IDLE and accepting a new start always take two
   // separate edges.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start)              state_d = MAC;
         MAC:  if (idx_q == LAST_IDX)  state_d = SAT;
         SAT:                          state_d = HOLD;
         HOLD: if (out_ready)          state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // Output decode: busy comes straight from the state; result and out_valid
   // are registered so they stay stable under backpressure.
   always_comb begin
      busy      = (state_q != IDLE);
      out_valid = out_valid_q;
      result    = result_q;
   end

   // The single shared multiplier works on whichever element idx points at.
   // Both operands are sign-extended to the full product width first.
   always_comb begin
      prod = win_q[idx_q] * wgt_q[idx_q];
   end

   fx_shift_sat #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_shift_sat (
      .acc_i (acc_q),
      .sat_o (sat_val)
   );

   // Datapath registers. Operands are snapshotted on the accepting edge so the
   // upstream block is free to change during the MAC sweep. The accumulator is
   // cleared at start, which is what keeps an aborted run from leaking into
   // the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < BLOCK_SIZE; k++) begin
            win_q[k] <= '0;
            wgt_q[k] <= '0;
         end
         idx_q       <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  for (int k = 0; k < BLOCK_SIZE; k++) begin
                     win_q[k] <= window_in[k*DATA_WIDTH +: DATA_WIDTH];
                     wgt_q[k] <= weight_in[k*DATA_WIDTH +: DATA_WIDTH];
                  end
                  acc_q <= '0;
                  idx_q <= '0;
               end
            end
            MAC: begin
               acc_q <= acc_q + ACC_WIDTH'(prod);
               idx_q <= idx_q + 1'b1;
            end
            SAT: begin
               result_q    <= sat_val;
               out_valid_q <= 1'b1;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_mac.sv
// -----------------------------------------------------------------------------
// tb_conv_window_mac
// Self-checking bench for conv_window_mac: a protocol-level reference model
// (plain integer dot product, shift, clamp, cycle count) compared every cycle,
// plus hand-computed literal expectations for each directed vector.
// Honours CONV_RELU_EN for the expected values.
// -----------------------------------------------------------------------------
module tb_conv_window_mac;
   import cnn_pkg::*;

   localparam int DW = DEF_DATA_WIDTH;
   localparam int BS = DEF_BLOCK_SIZE;
   localparam int FB = DEF_FRAC_BITS;
   localparam int LATENCY = 26;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [DW*BS-1:0]  window_in = '0;
   logic [DW*BS-1:0]  weight_in = '0;
   logic              busy;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DW-1:0]     result;

   int checkCount = 0;
   int passCount  = 0;
   bit running    = 1'b1;

   // Reference-model state: phase 0 idle, 1 computing, 2 holding result.
   int            mPhase  = 0;
   int            mCnt    = 0;
   bit            mValid  = 1'b0;
   logic [DW-1:0] mResult = '0;
   logic [DW-1:0] mPending = '0;

   conv_window_mac dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .window_in (window_in),
      .weight_in (weight_in),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   // Straight arithmetic definition of the expected result.
   function automatic logic [DW-1:0] dotModel(input logic [DW*BS-1:0] w,
                                              input logic [DW*BS-1:0] g);
      longint sum;
      longint scaled;
      logic signed [DW-1:0] a;
      logic signed [DW-1:0] b;
      sum = 0;
      for (int k = 0; k < BS; k++) begin
         a = w[k*DW +: DW];
         b = g[k*DW +: DW];
         sum += longint'(a) * longint'(b);
      end
      scaled = sum >>> FB;
      if (scaled > 32767)  scaled = 32767;
      if (scaled < -32768) scaled = -32768;
`ifdef CONV_RELU_EN
      if (scaled < 0) scaled = 0;
`endif
      return DW'(scaled);
   endfunction

   function automatic logic [DW*BS-1:0] fillBlock(input logic [DW-1:0] v);
      logic [DW*BS-1:0] blk;
      for (int k = 0; k < BS; k++) blk[k*DW +: DW] = v;
      return blk;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: advances on the clock, follows the handshake rules and
   // counts the fixed latency from the accepting edge to valid.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mPhase = 0;
         mCnt   = 0;
         mValid = 1'b0;
         mResult = '0;
      end else begin
         case (mPhase)
            0: if (start) begin
                  mPending = dotModel(window_in, weight_in);
                  mCnt = 0;
                  mPhase = 1;
               end
            1: begin
                  mCnt++;
                  if (mCnt == LATENCY) begin
                     mValid = 1'b1;
                     mResult = mPending;
                     mPhase = 2;
                  end
               end
            default: if (out_ready) begin
                  mValid = 1'b0;
                  mPhase = 0;
               end
         endcase
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (running) begin
         checkOutput("busy", 32'(busy), 32'(mPhase != 0));
         checkOutput("out_valid", 32'(out_valid), 32'(mValid));
         checkOutput("result", 32'(result), 32'(mResult));
      end
   end

   // Present a block and pulse start for exactly one edge.
   task automatic applyStimulus(input logic [DW*BS-1:0] w, input logic [DW*BS-1:0] g);
      @(negedge clk);
      window_in = w;
      weight_in = g;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait for valid with a bound, check latency and the literal result.
   // pokeStart scrambles start and the input blocks while the engine is busy.
   task automatic waitResult(input string name, input logic [DW-1:0] expLit,
                             input bit pokeStart);
      int cycles;
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 100) begin
         if (pokeStart) begin
            start = (cycles % 3 == 0);
            window_in = fillBlock(DW'($urandom));
            weight_in = fillBlock(DW'($urandom));
         end
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
      checkOutput({name, "_latency"}, 32'(cycles), 32'(LATENCY));
      checkOutput({name, "_literal"}, 32'(result), 32'(expLit));
   endtask

   task automatic finishOp();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("valid_drop", 32'(out_valid), 32'd0);
   endtask

   logic [DW*BS-1:0] ramp;
   logic [DW-1:0] expMin;
   logic [DW-1:0] expNeg;

   initial begin
`ifdef CONV_RELU_EN
      expMin = 16'h0000;
      expNeg = 16'h0000;
`else
      expMin = 16'h8000;
      expNeg = 16'hE700;
`endif
      for (int k = 0; k < BS; k++) ramp[k*DW +: DW] = DW'(k);

      // Pin the model itself against hand-computed values.
      checkOutput("model_identity", 32'(dotModel(fillBlock(16'h0100), fillBlock(16'h0100))), 32'h1900);
      checkOutput("model_ramp", 32'(dotModel(ramp, fillBlock(16'h0100))), 32'h012C);
      checkOutput("model_neg", 32'(dotModel(fillBlock(16'h0100), fillBlock(16'hFF00))), 32'(expNeg));

      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_result", 32'(result), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] identity window");
      applyStimulus(fillBlock(16'h0100), fillBlock(16'h0100));
      waitResult("identity", 16'h1900, 1'b0);
      finishOp();

      $display("[TB] ramp pattern");
      applyStimulus(ramp, fillBlock(16'h0100));
      waitResult("ramp", 16'h012C, 1'b0);
      finishOp();

      $display("[TB] saturation");
      applyStimulus(fillBlock(16'h7FFF), fillBlock(16'h7FFF));
      waitResult("sat_pos", 16'h7FFF, 1'b0);
      finishOp();
      applyStimulus(fillBlock(16'h8000), fillBlock(16'h7FFF));
      waitResult("sat_neg", expMin, 1'b0);
      finishOp();

      $display("[TB] negative weights");
      applyStimulus(fillBlock(16'h0100), fillBlock(16'hFF00));
      waitResult("negative", expNeg, 1'b0);
      finishOp();

      $display("[TB] backpressure and ignored start");
      applyStimulus(fillBlock(16'h0100), fillBlock(16'h0100));
      waitResult("bp", 16'h1900, 1'b1);
      for (int i = 0; i < 10; i++) begin
         start = i[0];
         window_in = fillBlock(16'h0200);
         @(negedge clk);
         checkOutput("bp_hold_result", 32'(result), 32'h1900);
         checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      start = 1'b0;
      finishOp();
      // Back-to-back start right after the handshake edge must be accepted.
      window_in = ramp;
      weight_in = fillBlock(16'h0100);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput("turnaround_busy", 32'(busy), 32'd1);
      waitResult("turnaround", 16'h012C, 1'b0);
      finishOp();

      $display("[TB] reset mid-MAC");
      applyStimulus(fillBlock(16'h0300), fillBlock(16'h0300));
      repeat (9) @(negedge clk);
      @(posedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_result", 32'(result), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(fillBlock(16'h0100), fillBlock(16'h0100));
      waitResult("post_reset", 16'h1900, 1'b0);
      finishOp();

      repeat (2) @(negedge clk);
      running = 1'b0;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
